// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse timing detector and its downstream decoder.
package morse_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    SPACE    = 2'd1,
    MARK     = 2'd2
  } state_e;

  // Symbol codes as seen by the decoder.
  localparam logic [2:0] SYM_NONE = 3'd0;
  localparam logic [2:0] SYM_DOT  = 3'd1;
  localparam logic [2:0] SYM_DASH = 3'd2;
  localparam logic [2:0] SYM_CHAR = 3'd3;
  localparam logic [2:0] SYM_WORD = 3'd4;
  localparam logic [2:0] SYM_ERR  = 3'd5;

  localparam int DEF_UNIT_CYCLES = 1;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_DOT_MAX     = 1;
  localparam int DEF_DASH_MAX    = 3;
  localparam int DEF_CHAR_GAP    = 3;
  localparam int DEF_WORD_GAP    = 7;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/morse_timing_detector_if.sv
// Keyed input and classified-symbol outputs of the Morse timing detector.
interface morse_timing_detector_if #(
  parameter int CNT_W = 4
);
  logic             din;
  logic             dot;
  logic             dash;
  logic             ch_s;
  logic             w_s;
  logic             err;
  logic             en;
  logic [CNT_W-1:0] run_len;

  modport master (output din, input dot, dash, ch_s, w_s, err, en, run_len);
  modport slave  (input din, output dot, dash, ch_s, w_s, err, en, run_len);
endinterface

// File: rtl/morse_unit_tick.sv
// Prescaler producing a one-cycle tick every UNIT_CYCLES clocks (one Morse unit).
module morse_unit_tick #(
  parameter int UNIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Wrap at the last count so the tick lands on the final cycle of each unit.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);
endmodule

// File: rtl/morse_timing_detector.sv
// Morse mark/space classifier; define MORSE_DEGLITCH_EN to add a synchroniser and
// a 3-tap majority filter on the sampled input.
module morse_timing_detector
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = DEF_UNIT_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DOT_MAX     = DEF_DOT_MAX,
  parameter int DASH_MAX    = DEF_DASH_MAX,
  parameter int CHAR_GAP    = DEF_CHAR_GAP,
  parameter int WORD_GAP    = DEF_WORD_GAP
) (
  input  logic                    clk,
  input  logic                    reset,
  morse_timing_detector_if.slave  io
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DOT_V   = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] DASH_V  = CNT_W'(DASH_MAX);
  localparam logic [CNT_W-1:0] CHAR_V  = CNT_W'(CHAR_GAP);
  localparam logic [CNT_W-1:0] WORD_V  = CNT_W'(WORD_GAP);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic tick_s;
  logic s_s;

  morse_unit_tick #(.UNIT_CYCLES(UNIT_CYCLES)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick_s)
  );

`ifdef MORSE_DEGLITCH_EN
  logic [1:0] sync_q, sync_d;
  logic [2:0] hist_q, hist_d;

  // History only advances on ticks, so the vote spans three Morse units.
  always_comb begin
    sync_d = {sync_q[0], io.din};
    hist_d = hist_q;
    if (tick_s) begin
      hist_d = {hist_q[1:0], sync_q[1]};
    end else begin
      hist_d = hist_q;
    end
  end

  // Synchroniser and majority history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
      hist_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign s_s = maj3(hist_q);
`else
  assign s_s = io.din;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic             char_pend_q, char_pend_d;
  logic             word_pend_q, word_pend_d;
  logic             dot_q, dot_d, dash_q, dash_d, ch_q, ch_d, w_q, w_d, err_q, err_d, en_q, en_d;

  // Classifier next-state and pulse generation; state only moves on ticks.
  always_comb begin
    state_d     = state_q;
    run_len_d   = run_len_q;
    char_pend_d = char_pend_q;
    word_pend_d = word_pend_q;
    dot_d       = 1'b0;
    dash_d      = 1'b0;
    ch_d        = 1'b0;
    w_d         = 1'b0;
    err_d       = 1'b0;
    if (tick_s) begin
      case (state_q)
        WAIT_LOW: begin
          if (s_s) begin
            state_d = WAIT_LOW;
          end else begin
            // Entering as already idle: no gap pulses can fire from here.
            state_d   = SPACE;
            run_len_d = WORD_V;
          end
        end
        SPACE: begin
          if (s_s) begin
            state_d   = MARK;
            run_len_d = CNT_ONE;
          end else begin
            run_len_d = sat_inc(run_len_q);
            if ((run_len_d == CHAR_V) && char_pend_q) begin
              ch_d        = 1'b1;
              char_pend_d = 1'b0;
            end else if ((run_len_d == WORD_V) && word_pend_q) begin
              w_d         = 1'b1;
              word_pend_d = 1'b0;
            end else begin
              ch_d = 1'b0;
            end
          end
        end
        MARK: begin
          if (s_s) begin
            run_len_d = sat_inc(run_len_q);
          end else begin
            state_d   = SPACE;
            run_len_d = CNT_ONE;
            if (run_len_q <= DOT_V) begin
              dot_d       = 1'b1;
              char_pend_d = 1'b1;
              word_pend_d = 1'b1;
            end else if (run_len_q <= DASH_V) begin
              dash_d      = 1'b1;
              char_pend_d = 1'b1;
              word_pend_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: begin
          state_d   = WAIT_LOW;
          run_len_d = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    en_d = dot_d | dash_d | ch_d | w_d;
  end

  // Classifier state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_LOW;
      run_len_q   <= '0;
      char_pend_q <= 1'b0;
      word_pend_q <= 1'b0;
      dot_q       <= 1'b0;
      dash_q      <= 1'b0;
      ch_q        <= 1'b0;
      w_q         <= 1'b0;
      err_q       <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      char_pend_q <= char_pend_d;
      word_pend_q <= word_pend_d;
      dot_q       <= dot_d;
      dash_q      <= dash_d;
      ch_q        <= ch_d;
      w_q         <= w_d;
      err_q       <= err_d;
      en_q        <= en_d;
    end
  end

  assign io.dot     = dot_q;
  assign io.dash    = dash_q;
  assign io.ch_s    = ch_q;
  assign io.w_s     = w_q;
  assign io.err     = err_q;
  assign io.en      = en_q;
  assign io.run_len = run_len_q;
endmodule

// File: tb/tb_morse_timing_detector.sv
// Scoreboard bench: unit A runs at one sample per unit, unit B at four clocks per unit.
module tb_morse_timing_detector;
  import morse_pkg::*;

`ifdef MORSE_DEGLITCH_EN
  localparam int TB_DOT_MAX = 2;
`else
  localparam int TB_DOT_MAX = 1;
`endif

  typedef struct packed {
    logic [2:0]  code;
    logic [31:0] cyc;
  } exp_t;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   cyc;
  int   checks;
  int   errors;
  int   rb;
  int   base;
  exp_t q_a[$];
  exp_t q_b[$];

  morse_timing_detector_if #(.CNT_W(4)) io_a ();
  morse_timing_detector_if #(.CNT_W(4)) io_b ();

  morse_timing_detector #(
    .UNIT_CYCLES(1), .CNT_W(4), .DOT_MAX(TB_DOT_MAX), .DASH_MAX(3), .CHAR_GAP(3), .WORD_GAP(7)
  ) u_a (.clk(clk), .reset(rst_a), .io(io_a));

  morse_timing_detector #(
    .UNIT_CYCLES(4), .CNT_W(4), .DOT_MAX(TB_DOT_MAX), .DASH_MAX(3), .CHAR_GAP(3), .WORD_GAP(7)
  ) u_b (.clk(clk), .reset(rst_b), .io(io_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int qsize(input int id);
    if (id == 0) return q_a.size();
    else return q_b.size();
  endfunction

  function automatic exp_t qfront(input int id);
    if (id == 0) return q_a[0];
    else return q_b[0];
  endfunction

  function automatic exp_t qpop(input int id);
    if (id == 0) return q_a.pop_front();
    else return q_b.pop_front();
  endfunction

  task automatic push(input int id, input logic [2:0] code, input int at);
    exp_t e;
    e.code = code;
    e.cyc  = 32'(at);
    if (id == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  // p = {err, w_s, ch_s, dash, dot}
  task automatic mon(input int id, input logic [4:0] p, input logic en_o);
    exp_t       e;
    logic [2:0] code;
    checks++;
    assert (($countones(p) <= 1) === 1'b1) else begin
      errors++; $error("FAIL onehot%0d: pulses=%b required at most one high", id, p);
    end
    if (p != 5'b0) begin
      code = p[0] ? SYM_DOT : p[1] ? SYM_DASH : p[2] ? SYM_CHAR : p[3] ? SYM_WORD : SYM_ERR;
      checks++;
      assert ((qsize(id) != 0) === 1'b1) else begin
        errors++; $error("FAIL unexpected%0d: code %0d at cyc %0d, required no pulse", id, code, cyc);
      end
      if (qsize(id) != 0) begin
        e = qpop(id);
        checks++;
        assert (code === e.code) else begin
          errors++; $error("FAIL code%0d: got %0d required %0d (cyc %0d)", id, code, e.code, cyc);
        end
        checks++;
        assert (32'(cyc) === e.cyc) else begin
          errors++; $error("FAIL time%0d: code %0d at cyc %0d required cyc %0d", id, code, cyc, e.cyc);
        end
        checks++;
        assert (en_o === (e.code != SYM_ERR)) else begin
          errors++; $error("FAIL en%0d: got %b required %b (cyc %0d)", id, en_o, e.code != SYM_ERR, cyc);
        end
      end
    end else begin
      checks++;
      assert (en_o === 1'b0) else begin
        errors++; $error("FAIL en_idle%0d: got %b required 0 (cyc %0d)", id, en_o, cyc);
      end
    end
    if (qsize(id) != 0) begin
      e = qfront(id);
      checks++;
      assert ((e.cyc >= 32'(cyc)) === 1'b1) else begin
        errors++; $error("FAIL missed%0d: code %0d absent at cyc %0d (now %0d)", id, e.code, e.cyc, cyc);
        e = qpop(id);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, {io_a.err, io_a.w_s, io_a.ch_s, io_a.dash, io_a.dot}, io_a.en);
    mon(1, {io_b.err, io_b.w_s, io_b.ch_s, io_b.dash, io_b.dot}, io_b.en);
  end

  task automatic chk_len(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++; $error("FAIL %s: run_len %0d required %0d", tag, obs, exp_v);
    end
  endtask

  task automatic drv_a(input logic v, input int n);
    repeat (n) begin
      io_a.din = v;
      @(negedge clk);
    end
  endtask

  task automatic drv_b(input logic v, input int n);
    repeat (n) begin
      io_b.din = v;
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    io_a.din = 1'b0;
    io_b.din = 1'b0;
    repeat (3) @(negedge clk);
    chk_len("reset_a", io_a.run_len, 4'd0);
    chk_len("reset_b", io_b.run_len, 4'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    rb = cyc;

`ifdef MORSE_DEGLITCH_EN
    // Dot of two units, then a one-unit glitch inside the following space.
    base = cyc;
    push(0, SYM_DOT,  base + 17);
    push(0, SYM_CHAR, base + 19);
    push(0, SYM_WORD, base + 23);
    drv_a(1'b0, 10);
    drv_a(1'b1, 2);
    drv_a(1'b0, 5);
    drv_a(1'b1, 1);
    drv_a(1'b0, 12);
    chk_len("deglitch_space", io_a.run_len, 4'd14);
`else
    // Dot, one-unit intra gap, 3-unit dash, then a full word gap.
    base = cyc;
    push(0, SYM_DOT,  base + 4);
    push(0, SYM_DASH, base + 8);
    push(0, SYM_CHAR, base + 10);
    push(0, SYM_WORD, base + 14);
    drv_a(1'b0, 1);
    chk_len("idle_entry", io_a.run_len, 4'd7);
    drv_a(1'b0, 1);
    drv_a(1'b1, 1);
    drv_a(1'b0, 1);
    drv_a(1'b1, 3);
    drv_a(1'b0, 12);
    chk_len("long_space", io_a.run_len, 4'd12);

    // 5-unit mark: error, and no character gap afterwards.
    base = cyc;
    push(0, SYM_ERR, base + 6);
    drv_a(1'b1, 5);
    drv_a(1'b0, 11);

    // DASH_MAX+1 boundary.
    base = cyc;
    push(0, SYM_ERR, base + 5);
    drv_a(1'b1, 4);
    drv_a(1'b0, 4);

    // Error mark keeps the pending character/word gap from the preceding dash.
    base = cyc;
    push(0, SYM_DASH, base + 3);
    push(0, SYM_ERR,  base + 9);
    push(0, SYM_CHAR, base + 11);
    push(0, SYM_WORD, base + 15);
    drv_a(1'b1, 2);
    drv_a(1'b0, 1);
    drv_a(1'b1, 5);
    drv_a(1'b0, 10);

    // Word gap completes after an interrupting error mark.
    base = cyc;
    push(0, SYM_DOT,  base + 2);
    push(0, SYM_CHAR, base + 4);
    push(0, SYM_ERR,  base + 11);
    push(0, SYM_WORD, base + 17);
    drv_a(1'b1, 1);
    drv_a(1'b0, 4);
    drv_a(1'b1, 5);
    drv_a(1'b0, 9);

    // Saturated mark.
    base = cyc;
    push(0, SYM_ERR, base + 21);
    drv_a(1'b1, 20);
    chk_len("saturate", io_a.run_len, 4'd15);
    drv_a(1'b0, 9);

    // Reset two units into a dash discards it and the pending gaps.
    base = cyc;
    push(0, SYM_DOT,  base + 2);
    push(0, SYM_DOT,  base + 19);
    push(0, SYM_CHAR, base + 21);
    push(0, SYM_WORD, base + 25);
    drv_a(1'b1, 1);
    drv_a(1'b0, 1);
    drv_a(1'b1, 2);
    chk_len("mid_dash", io_a.run_len, 4'd2);
    rst_a = 1'b1;
    @(negedge clk);
    chk_len("mid_reset", io_a.run_len, 4'd0);
    rst_a = 1'b0;
    drv_a(1'b1, 4);
    chk_len("wait_low", io_a.run_len, 4'd0);
    drv_a(1'b0, 8);
    drv_a(1'b1, 1);
    drv_a(1'b0, 10);

    // Four clocks per unit: aligned dot, then a 2-clock mark straddling a tick.
    while (((cyc - rb) % 4) != 0) @(negedge clk);
    base = cyc;
    push(1, SYM_DOT,  base + 8);
    push(1, SYM_CHAR, base + 16);
    push(1, SYM_WORD, base + 32);
    push(1, SYM_DOT,  base + 44);
    push(1, SYM_CHAR, base + 52);
    push(1, SYM_WORD, base + 68);
    drv_b(1'b1, 4);
    drv_b(1'b0, 35);
    drv_b(1'b1, 2);
    drv_b(1'b0, 34);
`endif

    repeat (4) @(negedge clk);
    checks++;
    assert (q_a.size() === 0) else begin
      errors++; $error("FAIL drain_a: %0d expected pulses outstanding, required 0", q_a.size());
    end
    checks++;
    assert (q_b.size() === 0) else begin
      errors++; $error("FAIL drain_b: %0d expected pulses outstanding, required 0", q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
